bpsk_tx_framer: RTL and testbench

//   Transmit sequencer for the BPSK modulator. Accepts payload bytes on a valid/ready stream.

---
 rtl/bpsk_tx_framer.sv | 186 ++++++++++++++++++
 tb/tb_bpsk_tx_framer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_framer.sv
// Transmit sequencer for the BPSK modulator: frames a valid/ready byte stream as
// preamble + sync word + payload + tail, one bit per SPS clocks on mod_en/mod_in.
module bpsk_tx_framer #(
    parameter int          SPS           = 8,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [7:0]  SYNC_WORD     = 8'hD3,
    parameter int          TAIL_BITS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       mod_en,
    output logic       mod_in,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [2:0] state_dbg
);

    // Stream handshake: a byte (s_data, s_last) transfers on a rising clk edge
    // where s_valid and s_ready are both 1; s_data/s_last are ignored otherwise.
    // s_valid may rise at any time, s_ready is only ever offered for one cycle.

    localparam int SYM_W    = $clog2(SPS);
    localparam int MAX_BITS = (PREAMBLE_BITS > 8)
                              ? ((PREAMBLE_BITS > TAIL_BITS) ? PREAMBLE_BITS : TAIL_BITS)
                              : ((TAIL_BITS > 8) ? TAIL_BITS : 8);
    localparam int BIT_W    = $clog2(MAX_BITS);

    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SPS - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0] TAIL_LAST = BIT_W'(TAIL_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        PAYLOAD  = 3'd3,
        TAIL     = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [SYM_W-1:0] sym_cnt, sym_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [7:0]       shreg, shreg_n;
    logic             last_q, last_n;

    logic sym_end;
    logic fetch;
    logic s_ready_n, mod_en_n, mod_in_n, busy_n, done_n, underrun_n;

    assign sym_end   = (sym_cnt == SYM_LAST);
    assign state_dbg = state;

    always_comb begin
        state_n    = state;
        sym_n      = sym_end ? '0 : sym_cnt + SYM_W'(1);
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        last_n     = last_q;
        underrun_n = 1'b0;
        fetch      = 1'b0;

        case (state)
            IDLE: begin
                sym_n = '0;
                bit_n = '0;
                if (s_valid) begin
                    state_n = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (sym_end) begin
                    if (bit_cnt == PRE_LAST) begin
                        state_n = SYNC;
                        bit_n   = '0;
                        shreg_n = SYNC_WORD;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            SYNC: begin
                if (sym_end) begin
                    if (bit_cnt == BYTE_LAST) begin
                        fetch = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        shreg_n = {shreg[6:0], 1'b0};
                    end
                end
            end
            PAYLOAD: begin
                if (sym_end) begin
                    if (bit_cnt == BYTE_LAST) begin
                        if (last_q) begin
                            state_n = TAIL;
                            bit_n   = '0;
                        end else begin
                            fetch = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        shreg_n = {shreg[6:0], 1'b0};
                    end
                end
            end
            TAIL: begin
                if (sym_end) begin
                    if (bit_cnt == TAIL_LAST) begin
                        state_n = IDLE;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sym_n   = '0;
                bit_n   = '0;
            end
        endcase

        // Byte boundary: either the next byte follows seamlessly or the frame is cut short.
        if (fetch) begin
            bit_n = '0;
            if (s_valid && s_ready) begin
                state_n = PAYLOAD;
                shreg_n = s_data;
                last_n  = s_last;
            end else begin
                state_n    = TAIL;
                underrun_n = 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        mod_en_n = (state_n != IDLE);
        busy_n   = (state_n != IDLE);
        mod_in_n = 1'b0;
        case (state_n)
            PREAMBLE:      mod_in_n = ~bit_n[0];
            SYNC, PAYLOAD: mod_in_n = shreg_n[7];
            default:       mod_in_n = 1'b0;
        endcase
        s_ready_n = (sym_n == SYM_LAST) && (bit_n == BYTE_LAST) &&
                    ((state_n == SYNC) || ((state_n == PAYLOAD) && !last_n));
        done_n    = (state_n == TAIL) && (bit_n == TAIL_LAST) && (sym_n == SYM_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            s_ready  <= 1'b0;
            mod_en   <= 1'b0;
            mod_in   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            sym_cnt  <= sym_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            last_q   <= last_n;
            s_ready  <= s_ready_n;
            mod_en   <= mod_en_n;
            mod_in   <= mod_in_n;
            busy     <= busy_n;
            done     <= done_n;
            underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Bench for bpsk_tx_framer: table of frames checked against a bit-level model
// queue, plus hand-written reset, back-to-back and mid-frame-reset sequences.
module tb_bpsk_tx_framer;

    localparam int         SPS  = 4;
    localparam int         PRE  = 8;
    localparam int         TAIL = 2;
    localparam logic [7:0] SYNC = 8'hD3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       mod_en;
    logic       mod_in;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    bpsk_tx_framer #(
        .SPS           (SPS),
        .PREAMBLE_BITS (PRE),
        .SYNC_WORD     (SYNC),
        .TAIL_BITS     (TAIL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .mod_en    (mod_en),
        .mod_in    (mod_in),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .state_dbg (state_dbg)
    );

    typedef struct {
        int              nbytes;
        logic [3:0][7:0] data;
        bit              last_mode;   // 1: final byte carries s_last; 0: source runs dry
        bit              hold;        // keep s_valid high with junk after the last byte
        int              exp_en;
        int              exp_ready;
        int              exp_underrun;
    } vec_t;

    vec_t       vecs[5];
    logic [0:0] exp_q[$];
    int         rdy_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b);
        for (int s = 0; s < SPS; s++) exp_q.push_back(b);
    endtask

    task automatic drive(input vec_t v, input int idx);
        if (idx < v.nbytes) begin
            s_valid = 1'b1;
            s_data  = v.data[idx];
            s_last  = v.last_mode && (idx == v.nbytes - 1);
        end else begin
            s_valid = v.hold && v.last_mode;
            s_data  = 8'($urandom_range(0, 255));
            s_last  = 1'($urandom_range(0, 1));
        end
    endtask

    // Runs one frame starting at a negedge with the DUT idle; returns at the
    // first negedge where mod_en is low again.
    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] sw;
        logic [7:0] b;
        int idx, cyc, ready_cnt, done_cnt, under_cnt, exp_len, under_at, fetches;
        bit ended;
        sw = SYNC;
        idx = 0; cyc = 0; ready_cnt = 0; done_cnt = 0; under_cnt = 0; ended = 1'b0;
        exp_q.delete();
        rdy_q.delete();
        for (int k = 0; k < PRE; k++) push_bit(~k[0]);
        for (int k = 7; k >= 0; k--) push_bit(sw[k]);
        for (int i = 0; i < v.nbytes; i++) begin
            b = v.data[i];
            for (int k = 7; k >= 0; k--) push_bit(b[k]);
        end
        for (int k = 0; k < TAIL; k++) push_bit(1'b0);
        exp_len  = exp_q.size();
        under_at = SPS * (PRE + 8 + 8 * v.nbytes) + 1;
        fetches  = v.last_mode ? v.nbytes : v.nbytes + 1;
        for (int f = 0; f < fetches; f++) rdy_q.push_back(SPS * (PRE + 8 + 8 * f));

        check({tag, " idle_before"}, mod_en, 0);
        drive(v, idx);
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (mod_en) begin
                if (cyc == 0) check({tag, " start_latency"}, t, 0);
                cyc++;
                if (exp_q.size() > 0) check({tag, " mod_in"}, mod_in, exp_q.pop_front());
                else                  check({tag, " frame_len"}, cyc, exp_len);
                check({tag, " busy"}, busy, 1);
            end else if (cyc > 0) begin
                ended = 1'b1;
                break;
            end
            if (s_ready) begin
                ready_cnt++;
                if (rdy_q.size() > 0) check({tag, " ready_at"}, cyc, rdy_q.pop_front());
                else                  check({tag, " ready_extra"}, s_ready, 0);
            end
            if (done) begin
                done_cnt++;
                check({tag, " done_at"}, cyc, exp_len);
            end
            if (underrun) begin
                under_cnt++;
                check({tag, " underrun_at"}, cyc, under_at);
            end
            drive(v, idx);
            if (s_ready && s_valid && idx < v.nbytes) idx++;
        end
        check({tag, " ended"}, ended, 1);
        check({tag, " en_cycles"}, cyc, v.exp_en);
        check({tag, " model_left"}, exp_q.size(), 0);
        check({tag, " ready_cnt"}, ready_cnt, v.exp_ready);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " underrun_cnt"}, under_cnt, v.exp_underrun);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " mod_in_after"}, mod_in, 0);
        check({tag, " done_after"}, done, 0);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pb;
        int  cyc, dseen;
        bit  hit, taken;

        vecs[0] = '{1, 32'h000000A5, 1'b1, 1'b1, 104, 1, 0};
        vecs[1] = '{2, 32'h0000FF00, 1'b1, 1'b1, 136, 2, 0};
        vecs[2] = '{1, 32'h0000003C, 1'b0, 1'b0, 104, 2, 1};
        vecs[3] = '{3, 32'h0, 1'b1, 1'b0, 168, 3, 0};
        vecs[4] = '{2, 32'h0, 1'b0, 1'b0, 136, 3, 1};
        for (int i = 0; i < 3; i++) vecs[3].data[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 2; i++) vecs[4].data[i] = 8'($urandom_range(0, 255));

        // Reset with the stream quiet.
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (2) @(negedge clk);
        check("rst s_ready", s_ready, 0);
        check("rst mod_en", mod_en, 0);
        check("rst mod_in", mod_in, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst underrun", underrun, 0);
        check("rst state", state_dbg, 0);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            idle(3);
        end

        // Back-to-back single-byte frames: the gap cycle is the idle_before check.
        run_frame(vecs[0], "b2b_a");
        run_frame(vecs[0], "b2b_b");
        idle(3);

        // Reset in the middle of payload bit 3.
        pb = 8'h5A; cyc = 0; dseen = 0; hit = 1'b0; taken = 1'b0;
        s_valid = 1'b1; s_data = pb; s_last = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (mod_en) cyc++;
            if (done) dseen++;
            if (cyc == SPS * (PRE + 8) + 3 * SPS + 1) begin
                hit = 1'b1;
                check("midrst bit3", mod_in, pb[4]);
                break;
            end
            if (taken) s_data = 8'h77;
            if (s_ready && s_valid) taken = 1'b1;
        end
        check("midrst reached", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst mod_en", mod_en, 0);
        check("midrst busy", busy, 0);
        check("midrst s_ready", s_ready, 0);
        check("midrst mod_in", mod_in, 0);
        check("midrst underrun", underrun, 0);
        check("midrst state", state_dbg, 0);
        if (done) dseen++;
        rst = 1'b0;
        s_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done) dseen++;
            check("midrst stays_idle", mod_en, 0);
        end
        check("midrst no_done", dseen, 0);
        run_frame(vecs[1], "after_rst");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
